// File: rtl/muldiv_unit_pkg.sv
// Shared encodings and operation decode for the iterative multiply/divide unit.
package muldiv_unit_pkg;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_MUL  = 5'd10;
    localparam logic [4:0] ALU_DIV  = 5'd11;
    localparam logic [4:0] ALU_DIVU = 5'd12;
    localparam logic [4:0] ALU_REM  = 5'd13;
    localparam logic [4:0] ALU_REMU = 5'd14;

    localparam logic [1:0] MUL_SEL_MUL    = 2'b00;
    localparam logic [1:0] MUL_SEL_MULH   = 2'b01;
    localparam logic [1:0] MUL_SEL_MULHSU = 2'b10;
    localparam logic [1:0] MUL_SEL_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        MD_ST_IDLE,
        MD_ST_ITER,
        MD_ST_FIX,
        MD_ST_DONE
    } md_state_e;

    typedef enum logic [2:0] {
        MD_OP_NONE,
        MD_OP_MUL_LO,
        MD_OP_MUL_HI,
        MD_OP_QUOT,
        MD_OP_REM
    } md_op_e;

    typedef struct packed {
        md_op_e op;
        logic   sign1;  // op1 interpreted as signed
        logic   sign2;  // op2 interpreted as signed
    } md_decode_t;

    function automatic md_decode_t md_decode(input logic [4:0] alu_sel, input logic [1:0] mul_sel);
        md_decode_t d;
        d = '{op: MD_OP_NONE, sign1: 1'b0, sign2: 1'b0};
        case (alu_sel)
            ALU_MUL: begin
                case (mul_sel)
                    MUL_SEL_MUL:    d.op = MD_OP_MUL_LO;
                    MUL_SEL_MULH:   d = '{op: MD_OP_MUL_HI, sign1: 1'b1, sign2: 1'b1};
                    MUL_SEL_MULHSU: d = '{op: MD_OP_MUL_HI, sign1: 1'b1, sign2: 1'b0};
                    default:        d.op = MD_OP_MUL_HI;
                endcase
            end
            ALU_DIV:  d = '{op: MD_OP_QUOT, sign1: 1'b1, sign2: 1'b1};
            ALU_DIVU: d.op = MD_OP_QUOT;
            ALU_REM:  d = '{op: MD_OP_REM, sign1: 1'b1, sign2: 1'b1};
            ALU_REMU: d.op = MD_OP_REM;
            default:  d.op = MD_OP_NONE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface muldiv_unit_if #(parameter int unsigned XLEN = 32);
    logic            req_valid;
    logic            req_ready;
    logic [4:0]      alu_sel;
    logic [1:0]      mul_sel;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            kill;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output req_valid, alu_sel, mul_sel, op1, op2, kill, resp_ready,
        input  req_ready, resp_valid, result, busy
    );

    modport slave (
        input  req_valid, alu_sel, mul_sel, op1, op2, kill, resp_ready,
        output req_ready, resp_valid, result, busy
    );
endinterface

// File: rtl/muldiv_unit.sv
// Radix-2 iterative multiply/divide unit: fixed XLEN+2 cycle latency from accept
// to resp_valid, result held until the consumer takes it.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);

    localparam int unsigned CW = $clog2(XLEN + 1);

    md_state_e         state, state_nxt;
    md_op_e            op_q;
    logic              neg_q;
    logic              b_zero_q;
    logic [XLEN-1:0]   op1_q;
    logic [XLEN-1:0]   addend_q;
    logic [2*XLEN-1:0] prod_q;
    logic [CW-1:0]     count_q;
    logic [XLEN-1:0]   result_q;

    md_decode_t        dec;
    logic              neg1, neg2;
    logic [XLEN-1:0]   mag1, mag2;
    logic              accept;

    // Operand magnitudes are shared by both the multiply and divide paths
    always_comb begin
        dec    = md_decode(bus.alu_sel, bus.mul_sel);
        neg1   = dec.sign1 & bus.op1[XLEN-1];
        neg2   = dec.sign2 & bus.op2[XLEN-1];
        mag1   = neg1 ? -bus.op1 : bus.op1;
        mag2   = neg2 ? -bus.op2 : bus.op2;
        accept = (state == MD_ST_IDLE) && bus.req_valid && !bus.kill;
    end

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] step_nxt;

    // prod_q holds {acc, multiplier} for mul and {remainder, dividend/quotient} for div
    always_comb begin
        mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, addend_q};
        div_diff = prod_q[2*XLEN-1:XLEN-1] - {1'b0, addend_q};
        if (op_q == MD_OP_QUOT || op_q == MD_OP_REM) begin
            if (!div_diff[XLEN])
                step_nxt = {div_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
            else
                step_nxt = {prod_q[2*XLEN-2:0], 1'b0};
        end else begin
            step_nxt = prod_q[0] ? {mul_sum, prod_q[XLEN-1:1]}
                                 : {1'b0, prod_q[2*XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] fix_in, fixed;
    logic [XLEN-1:0]   fix_result;

    always_comb begin
        case (op_q)
            MD_OP_QUOT: fix_in = {{XLEN{1'b0}}, prod_q[XLEN-1:0]};
            MD_OP_REM:  fix_in = {{XLEN{1'b0}}, prod_q[2*XLEN-1:XLEN]};
            default:    fix_in = prod_q;
        endcase
        fixed = neg_q ? ('0 - fix_in) : fix_in;
        case (op_q)
            MD_OP_MUL_LO: fix_result = fixed[XLEN-1:0];
            MD_OP_MUL_HI: fix_result = fixed[2*XLEN-1:XLEN];
            MD_OP_QUOT:   fix_result = b_zero_q ? '1 : fixed[XLEN-1:0];
            MD_OP_REM:    fix_result = b_zero_q ? op1_q : fixed[XLEN-1:0];
            default:      fix_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= MD_ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MD_ST_IDLE: if (accept) state_nxt = MD_ST_ITER;
            MD_ST_ITER: begin
                if (bus.kill)                  state_nxt = MD_ST_IDLE;
                else if (count_q == CW'(1))    state_nxt = MD_ST_FIX;
            end
            MD_ST_FIX:  state_nxt = bus.kill ? MD_ST_IDLE : MD_ST_DONE;
            MD_ST_DONE: if (bus.kill || bus.resp_ready) state_nxt = MD_ST_IDLE;
            default:    state_nxt = MD_ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state == MD_ST_IDLE) && !bus.kill;
        bus.busy       = (state != MD_ST_IDLE);
        bus.resp_valid = (state == MD_ST_DONE);
        bus.result     = result_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= MD_OP_NONE;
            neg_q    <= 1'b0;
            b_zero_q <= 1'b0;
            op1_q    <= '0;
            addend_q <= '0;
            prod_q   <= '0;
            count_q  <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q     <= dec.op;
            neg_q    <= (dec.op == MD_OP_REM) ? neg1 : (neg1 ^ neg2);
            b_zero_q <= (bus.op2 == '0);
            op1_q    <= bus.op1;
            count_q  <= CW'(XLEN);
            if (dec.op == MD_OP_QUOT || dec.op == MD_OP_REM) begin
                addend_q <= mag2;
                prod_q   <= {{XLEN{1'b0}}, mag1};
            end else begin
                addend_q <= mag1;
                prod_q   <= {{XLEN{1'b0}}, mag2};
            end
        end else if (state == MD_ST_ITER) begin
            prod_q  <= step_nxt;
            count_q <= count_q - CW'(1);
        end else if (state == MD_ST_FIX) begin
            result_q <= fix_result;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed spec cases plus random ops against a plain-arithmetic model.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int unsigned LAT = 34;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] res;
        int          c0;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          seen = 1'b0;
    logic [31:0] cur_exp = '0;
    int          rr_mode = 2;

    always @(posedge clk) cyc++;

    // resp_ready changes 2 time units after the edge so it never races the main sequence
    always @(posedge clk) begin
        #2;
        case (rr_mode)
            0:       bus.resp_ready = 1'($urandom_range(0, 1));
            1:       bus.resp_ready = 1'b0;
            default: bus.resp_ready = 1'b1;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [4:0] sel, input logic [1:0] ms,
                                          input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        logic [63:0]     pv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (sel)
            ALU_MUL: begin
                case (ms)
                    MUL_SEL_MUL:    begin up = ua * ub; pv = up; return pv[31:0]; end
                    MUL_SEL_MULH:   begin sp = sa * sb; pv = sp; return pv[63:32]; end
                    MUL_SEL_MULHSU: begin sp = sa * longint'(ub); pv = sp; return pv[63:32]; end
                    default:        begin up = ua * ub; pv = up; return pv[63:32]; end
                endcase
            end
            ALU_DIV:  begin if (b == 0) return 32'hFFFF_FFFF; sp = sa / sb; pv = sp; return pv[31:0]; end
            ALU_REM:  begin if (b == 0) return a; sp = sa % sb; pv = sp; return pv[31:0]; end
            ALU_DIVU: begin if (b == 0) return 32'hFFFF_FFFF; up = ua / ub; pv = up; return pv[31:0]; end
            ALU_REMU: begin if (b == 0) return a; up = ua % ub; pv = up; return pv[31:0]; end
            default:  return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic issue(input logic [4:0] sel, input logic [1:0] ms, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input bit push);
        int unsigned waited = 0;
        bus.req_valid = 1'b1;
        bus.alu_sel   = sel;
        bus.mul_sel   = ms;
        bus.op1       = a;
        bus.op2       = b;
        forever begin
            @(negedge clk);
            if (bus.req_ready) begin
                if (push) sb_q.push_back('{res: exp, c0: cyc});
                break;
            end
            waited++;
            if (waited > 300) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout actual=busy required=req_ready within 300 cycles");
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.alu_sel   = 5'($urandom);
        bus.op1       = $urandom;
        bus.op2       = $urandom;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((sb_q.size() != 0 || seen) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d pending required=0", sb_q.size());
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (!reset && bus.resp_valid) begin
            if (!seen) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp actual=resp_valid result=0x%08h required=no response", bus.result);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    cur_exp = e.res;
                    seen = 1'b1;
                    chk("result", bus.result, e.res);
                    chk("latency", 32'(cyc - e.c0), 32'(LAT));
                end
            end else begin
                chk("hold_result", bus.result, cur_exp);
            end
            if (bus.resp_ready) seen = 1'b0;
        end
    end

    typedef struct {
        logic [4:0]  sel;
        logic [1:0]  ms;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t dir_vecs[$] = '{
        '{ALU_MUL,  MUL_SEL_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB},
        '{ALU_MUL,  MUL_SEL_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
        '{ALU_MUL,  MUL_SEL_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
        '{ALU_MUL,  MUL_SEL_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF},
        '{ALU_DIV,  2'b00,          32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
        '{ALU_REM,  2'b00,          32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
        '{ALU_DIVU, 2'b00,          32'h0000_0007, 32'h0000_0002, 32'h0000_0003},
        '{ALU_REMU, 2'b00,          32'h0000_0007, 32'h0000_0002, 32'h0000_0001},
        '{ALU_DIV,  2'b00,          32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF},
        '{ALU_REMU, 2'b00,          32'h0000_0005, 32'h0000_0000, 32'h0000_0005},
        '{ALU_DIV,  2'b00,          32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
        '{ALU_REM,  2'b00,          32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000},
        '{ALU_ADD,  2'b00,          32'h0000_0003, 32'h0000_0004, 32'h0000_0000}
    };

    initial begin
        logic [4:0]  sel;
        logic [1:0]  ms;
        logic [31:0] a, b;
        int unsigned n;

        bus.req_valid  = 1'b0;
        bus.alu_sel    = '0;
        bus.mul_sel    = '0;
        bus.op1        = '0;
        bus.op2        = '0;
        bus.kill       = 1'b0;
        bus.resp_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_result", bus.result, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;

        rr_mode = 2;
        foreach (dir_vecs[i])
            issue(dir_vecs[i].sel, dir_vecs[i].ms, dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].exp, 1'b1);
        drain();

        // Consumer stalls for 5 cycles in DONE
        rr_mode = 1;
        issue(ALU_MUL, MUL_SEL_MUL, 32'd3, 32'd5, 32'd15, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.resp_valid && n < 60);
        for (int k = 0; k < 5; k++) begin
            chk("stall_resp_valid", 32'(bus.resp_valid), 32'd1);
            chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        rr_mode = 2;
        @(negedge clk);
        @(negedge clk);
        chk("after_hs_req_ready", 32'(bus.req_ready), 32'd1);
        chk("after_hs_resp_valid", 32'(bus.resp_valid), 32'd0);
        @(posedge clk); #1;

        // kill in the 10th ITER cycle
        issue(ALU_DIVU, 2'b00, 32'd100, 32'd7, 32'd0, 1'b0);
        repeat (9) begin @(posedge clk); #1; end
        bus.kill = 1'b1;
        @(posedge clk); #1;
        bus.kill = 1'b0;
        @(negedge clk);
        chk("kill_busy", 32'(bus.busy), 32'd0);
        chk("kill_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("kill_req_ready", 32'(bus.req_ready), 32'd1);
        repeat (40) @(posedge clk);
        #1;

        // kill in IDLE blocks acceptance
        bus.kill      = 1'b1;
        bus.req_valid = 1'b1;
        bus.alu_sel   = ALU_MUL;
        @(negedge clk);
        chk("idle_kill_req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        bus.kill      = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("idle_kill_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;

        // reset pulse mid-ITER
        issue(ALU_MUL, MUL_SEL_MULHU, 32'hFFFF_FFFF, 32'h1234_5678, 32'd0, 1'b0);
        repeat (5) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midreset_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("midreset_busy", 32'(bus.busy), 32'd0);
        chk("midreset_result", bus.result, 32'd0);
        chk("midreset_req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;

        rr_mode = 0;
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 8))
                0: begin sel = ALU_MUL;  ms = MUL_SEL_MUL;    end
                1: begin sel = ALU_MUL;  ms = MUL_SEL_MULH;   end
                2: begin sel = ALU_MUL;  ms = MUL_SEL_MULHSU; end
                3: begin sel = ALU_MUL;  ms = MUL_SEL_MULHU;  end
                4: begin sel = ALU_DIV;  ms = 2'($urandom);   end
                5: begin sel = ALU_DIVU; ms = 2'($urandom);   end
                6: begin sel = ALU_REM;  ms = 2'($urandom);   end
                7: begin sel = ALU_REMU; ms = 2'($urandom);   end
                default: begin sel = ALU_ADD; ms = 2'($urandom); end
            endcase
            a = rand_operand();
            b = rand_operand();
            issue(sel, ms, a, b, model(sel, ms, a, b), 1'b1);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
